eth_phy_10g_block_lock_ctrl: RTL and testbench



---
 rtl/eth_phy_10g_pkg.sv | 34 +++
 rtl/eth_phy_10g_ber_mon.sv | 59 +++++
 rtl/eth_phy_10g_block_lock_ctrl.sv | 163 ++++++++++++++++
 tb/tb_eth_phy_10g_block_lock_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_phy_10g_pkg.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_pkg
// Shared definitions for the 10GBASE-R receive block-lock logic:
//   - SYNC_DATA / SYNC_CTRL sync-header codes
//   - block-lock FSM state encodings (HUNT, SLIP_WAIT, LOCKED)
//   - default LOCK_CNT / WIN_CNT / BAD_LIMIT values and the BER threshold
//   - hdr_is_valid(): sync-header validity test
//   - sat_inc8(): 8-bit saturating increment
// -----------------------------------------------------------------------------
package eth_phy_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [1:0] ST_HUNT      = 2'd0;
    localparam logic [1:0] ST_SLIP_WAIT = 2'd1;
    localparam logic [1:0] ST_LOCKED    = 2'd2;

    localparam int DEF_LOCK_CNT  = 64;
    localparam int DEF_WIN_CNT   = 64;
    localparam int DEF_BAD_LIMIT = 16;

    // Invalid headers per BER interval that raise hi_ber.
    localparam int BER_BAD_LIMIT = 16;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/eth_phy_10g_ber_mon.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_ber_mon
// Counts accepted headers and invalid headers over BER_WINDOW-header
// intervals. At each interval boundary hi_ber is refreshed (1 when at least
// BER_BAD_LIMIT invalid headers were seen) and both counters restart.
// Ports:
//   i_clk      RX block clock
//   i_reset    synchronous active-high reset
//   i_accept   a header was accepted this cycle
//   i_invalid  the current header is invalid (qualified by i_accept)
//   o_hi_ber   high bit-error-rate flag, registered
// -----------------------------------------------------------------------------
module eth_phy_10g_ber_mon
    import eth_phy_10g_pkg::*;
#(
    parameter int BER_WINDOW = 1024
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_accept,
    input  logic i_invalid,
    output logic o_hi_ber
);

    localparam int HW = $clog2(BER_WINDOW + 1);
    localparam int EW = $clog2(BER_BAD_LIMIT + 1);
    localparam logic [HW-1:0] HDR_LAST = HW'(BER_WINDOW);
    localparam logic [EW-1:0] ERR_SAT  = EW'(BER_BAD_LIMIT);

    logic [HW-1:0] r_hdr_cnt;
    logic [EW-1:0] r_err_cnt;
    logic          r_hi_ber;
    logic [HW-1:0] w_hdr_nxt;
    logic [EW-1:0] w_err_nxt;

    assign w_hdr_nxt = r_hdr_cnt + HW'(1);
    // The error count only needs to reach the threshold, so it saturates there.
    assign w_err_nxt = (r_err_cnt == ERR_SAT) ? r_err_cnt : r_err_cnt + EW'(i_invalid);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hdr_cnt <= '0;
            r_err_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (i_accept) begin
            if (w_hdr_nxt == HDR_LAST) begin
                r_hi_ber  <= (w_err_nxt == ERR_SAT);
                r_hdr_cnt <= '0;
                r_err_cnt <= '0;
            end else begin
                r_hdr_cnt <= w_hdr_nxt;
                r_err_cnt <= w_err_nxt;
            end
        end
    end

    assign o_hi_ber = r_hi_ber;

endmodule

// File: rtl/eth_phy_10g_block_lock_ctrl.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_block_lock_ctrl
// 10GBASE-R block-lock controller. Hunts for sync-header alignment by
// commanding single-bit slips, declares lock after LOCK_CNT consecutive valid
// headers, and drops lock when BAD_LIMIT invalid headers land in one
// WIN_CNT-header window.
// Optional feature: define ETH_PHY_10G_BER_MON_EN to build the BER monitor
// driving o_hi_ber; otherwise o_hi_ber is tied 0.
// Ports:
//   i_clk          RX block clock
//   i_reset        synchronous active-high reset
//   i_hdr_in       sync header of the current block
//   i_hdr_valid    i_hdr_in carries a new header this cycle
//   o_bitslip      one-cycle pulse: gearbox shifts alignment by one bit
//   o_block_lock   block alignment achieved
//   o_hdr_err      one-cycle pulse per accepted invalid header
//   o_slip_count   bitslips since reset, saturating at 255
//   o_hi_ber       high BER flag
// -----------------------------------------------------------------------------
module eth_phy_10g_block_lock_ctrl
    import eth_phy_10g_pkg::*;
#(
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int WIN_CNT    = DEF_WIN_CNT,
    parameter int BAD_LIMIT  = DEF_BAD_LIMIT,
    parameter int SLIP_WAIT  = 4,
    parameter int BER_WINDOW = 1024
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_hdr_in,
    input  logic       i_hdr_valid,
    output logic       o_bitslip,
    output logic       o_block_lock,
    output logic       o_hdr_err,
    output logic [7:0] o_slip_count,
    output logic       o_hi_ber
);

    localparam int SH_W   = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN_CNT + 1);
    localparam int BAD_W  = $clog2(BAD_LIMIT + 1);
    localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;

    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CNT);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT);
    // The bitslip cycle is always spent in SLIP_WAIT, so even SLIP_WAIT=0
    // costs one cycle there.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

    logic [1:0]        r_state;
    logic [SH_W-1:0]   r_sh_cnt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [BAD_W-1:0]  r_bad_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_bitslip;
    logic              r_block_lock;
    logic              r_hdr_err;
    logic [7:0]        r_slip_count;

    logic              w_accept;
    logic              w_invalid;
    logic [WIN_W-1:0]  w_win_nxt;
    logic [BAD_W-1:0]  w_bad_nxt;

    assign w_accept  = i_hdr_valid && (r_state != ST_SLIP_WAIT);
    assign w_invalid = ~hdr_is_valid(i_hdr_in);
    assign w_win_nxt = r_win_cnt + WIN_W'(1);
    assign w_bad_nxt = r_bad_cnt + BAD_W'(w_invalid);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_HUNT;
            r_sh_cnt     <= '0;
            r_win_cnt    <= '0;
            r_bad_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_bitslip    <= 1'b0;
            r_block_lock <= 1'b0;
            r_hdr_err    <= 1'b0;
            r_slip_count <= 8'd0;
        end else begin
            r_bitslip <= 1'b0;
            r_hdr_err <= w_accept & w_invalid;
            case (r_state)
                ST_HUNT: begin
                    if (w_accept) begin
                        if (w_invalid) begin
                            r_sh_cnt     <= '0;
                            r_bitslip    <= 1'b1;
                            r_slip_count <= sat_inc8(r_slip_count);
                            r_wait_cnt   <= '0;
                            r_state      <= ST_SLIP_WAIT;
                        end else if (r_sh_cnt == SH_LAST) begin
                            r_sh_cnt     <= '0;
                            r_win_cnt    <= '0;
                            r_bad_cnt    <= '0;
                            r_block_lock <= 1'b1;
                            r_state      <= ST_LOCKED;
                        end else begin
                            r_sh_cnt <= r_sh_cnt + SH_W'(1);
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    // Counts cycles, not headers: the gearbox settles in time.
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_HUNT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (w_accept) begin
                        // Loss of lock is tested first so it wins when the
                        // last header of a window is also the limiting bad one.
                        if (w_bad_nxt == BAD_LAST) begin
                            r_win_cnt    <= '0;
                            r_bad_cnt    <= '0;
                            r_block_lock <= 1'b0;
                            r_bitslip    <= 1'b1;
                            r_slip_count <= sat_inc8(r_slip_count);
                            r_wait_cnt   <= '0;
                            r_state      <= ST_SLIP_WAIT;
                        end else if (w_win_nxt == WIN_LAST) begin
                            r_win_cnt <= '0;
                            r_bad_cnt <= '0;
                        end else begin
                            r_win_cnt <= w_win_nxt;
                            r_bad_cnt <= w_bad_nxt;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_HUNT;
                    r_block_lock <= 1'b0;
                end
            endcase
        end
    end

    assign o_bitslip    = r_bitslip;
    assign o_block_lock = r_block_lock;
    assign o_hdr_err    = r_hdr_err;
    assign o_slip_count = r_slip_count;

`ifdef ETH_PHY_10G_BER_MON_EN
    eth_phy_10g_ber_mon #(
        .BER_WINDOW (BER_WINDOW)
    ) u_ber_mon (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_accept  (w_accept),
        .i_invalid (w_invalid),
        .o_hi_ber  (o_hi_ber)
    );
`else
    assign o_hi_ber = 1'b0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_block_lock_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_eth_phy_10g_block_lock_ctrl
// Directed scenarios plus a randomized header stream. A behavioural model
// tracks lock status, ignored-cycle budget after each slip and per-window
// counts; outputs are compared against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_eth_phy_10g_block_lock_ctrl;

    localparam int LOCK = 64;
    localparam int WIN  = 64;
    localparam int BADL = 16;
    localparam int SW   = 4;
    localparam int BERW = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] hdr_in = 2'b01;
    logic       hdr_valid = 1'b0;
    logic       bitslip, block_lock, hdr_err, hi_ber;
    logic [7:0] slip_count;

    always #5 clk = ~clk;

    eth_phy_10g_block_lock_ctrl #(
        .LOCK_CNT   (LOCK),
        .WIN_CNT    (WIN),
        .BAD_LIMIT  (BADL),
        .SLIP_WAIT  (SW),
        .BER_WINDOW (BERW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_hdr_in     (hdr_in),
        .i_hdr_valid  (hdr_valid),
        .o_bitslip    (bitslip),
        .o_block_lock (block_lock),
        .o_hdr_err    (hdr_err),
        .o_slip_count (slip_count),
        .o_hi_ber     (hi_ber)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_run, m_wait, m_hdrs, m_bads, m_slips, b_hdrs, b_bads;
    bit m_locked, e_slip, e_err, e_hiber, m_inv, m_doslip;

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_wait = 0; m_hdrs = 0; m_bads = 0; m_slips = 0;
            b_hdrs = 0; b_bads = 0;
            m_locked = 0; e_slip = 0; e_err = 0; e_hiber = 0;
        end else begin
            e_slip = 0; e_err = 0; m_doslip = 0;
            m_inv = (hdr_in == 2'b00) || (hdr_in == 2'b11);
            if (m_wait > 0) begin
                m_wait--;
            end else if (hdr_valid) begin
                e_err = m_inv;
`ifdef ETH_PHY_10G_BER_MON_EN
                b_hdrs++;
                if (m_inv) b_bads++;
                if (b_hdrs == BERW) begin
                    e_hiber = (b_bads >= 16);
                    b_hdrs = 0; b_bads = 0;
                end
`endif
                if (!m_locked) begin
                    if (m_inv) m_doslip = 1;
                    else begin
                        m_run++;
                        if (m_run == LOCK) begin
                            m_locked = 1; m_run = 0; m_hdrs = 0; m_bads = 0;
                        end
                    end
                end else begin
                    m_hdrs++;
                    if (m_inv) m_bads++;
                    if (m_bads == BADL) begin
                        m_locked = 0; m_doslip = 1;
                    end else if (m_hdrs == WIN) begin
                        m_hdrs = 0; m_bads = 0;
                    end
                end
                if (m_doslip) begin
                    e_slip = 1; m_run = 0; m_hdrs = 0; m_bads = 0;
                    if (m_slips < 255) m_slips++;
                    m_wait = (SW > 0) ? SW : 1;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    bit run_cmp = 0;
    int n_slip_pulses = 0;

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("bitslip", bitslip, e_slip);
            chk("block_lock", block_lock, m_locked);
            chk("hdr_err", hdr_err, e_err);
            chk("slip_count", slip_count, m_slips);
            chk("hi_ber", hi_ber, e_hiber);
            if (bitslip) n_slip_pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [1:0] h, input logic v);
        hdr_in = h; hdr_valid = v;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; hdr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic good_n(input int n);
        for (int i = 0; i < n; i++) cyc((i % 2) ? 2'b10 : 2'b01, 1'b1);
    endtask

    initial begin
        @(posedge clk); #1;
        run_cmp = 1;
        @(posedge clk); #1;
        chk("rst_bitslip", bitslip, 0);
        chk("rst_lock", block_lock, 0);
        chk("rst_hdr_err", hdr_err, 0);
        chk("rst_slip_count", slip_count, 0);
        chk("rst_hi_ber", hi_ber, 0);
        reset = 1'b0;

        // Lock acquisition from reset
        n_slip_pulses = 0;
        for (int i = 0; i < LOCK - 1; i++) cyc(2'b01, 1'b1);
        chk("lock_at63", block_lock, 0);
        cyc(2'b01, 1'b1);
        chk("lock_at64", block_lock, 1);
        chk("lock_no_slip", n_slip_pulses, 0);

        // Slip in HUNT and ignored headers
        do_reset();
        good_n(9);
        cyc(2'b11, 1'b1);
        chk("hunt_slip", bitslip, 1);
        chk("hunt_slip_cnt", slip_count, 1);
        for (int k = 0; k < SW; k++) begin
            cyc(2'b11, 1'b1);
            chk("wait_no_err", hdr_err, 0);
            chk("wait_no_slip", bitslip, 0);
        end
        good_n(LOCK - 1);
        chk("relock_at63", block_lock, 0);
        good_n(1);
        chk("relock_at64", block_lock, 1);
        chk("relock_slip_cnt", slip_count, 1);

        // Window 1: 15 bad -> lock kept
        for (int i = 0; i < WIN; i++)
            cyc((i % 4 == 1 && i < 60) ? 2'b00 : 2'b10, 1'b1);
        chk("win15_lock", block_lock, 1);
        // Window 2: one early bad -> lock kept (window cleared)
        for (int i = 0; i < WIN; i++)
            cyc((i == 2) ? 2'b11 : 2'b01, 1'b1);
        chk("win2_lock", block_lock, 1);
        // Window 3: 16th bad at header 61
        for (int i = 0; i < 61; i++)
            cyc((i % 4 == 0) ? 2'b00 : 2'b01, 1'b1);
        chk("win16_unlock", block_lock, 0);
        chk("win16_slip", bitslip, 1);
        chk("win16_slip_cnt", slip_count, 2);
        for (int k = 0; k < SW; k++) cyc(2'b01, 1'b0);

        // 64th header of a window is the 16th bad one
        good_n(LOCK);
        chk("relock2", block_lock, 1);
        for (int i = 0; i < WIN - 1; i++)
            cyc((i % 4 == 3) ? 2'b11 : 2'b10, 1'b1);
        chk("edge_lock_kept", block_lock, 1);
        cyc(2'b11, 1'b1);
        chk("edge_unlock", block_lock, 0);
        chk("edge_slip", bitslip, 1);
        for (int k = 0; k < SW; k++) cyc(2'b01, 1'b0);

        // Randomized stream with phased error rates and valid gaps
        for (int n = 0; n < 3000; n++) begin
            int rate;
            logic [1:0] h;
            rate = (n < 750) ? 1 : (n < 1500) ? 6 : (n < 2250) ? 20 : 50;
            if ($urandom_range(0, 99) < rate)
                h = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            else
                h = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            cyc(h, ($urandom_range(0, 3) != 0));
        end

        // Slip counter saturation, then reset in SLIP_WAIT
        do_reset();
        for (int k = 0; k < 300 * (SW + 1); k++) cyc(2'b00, 1'b1);
        chk("slip_sat", slip_count, 255);
        cyc(2'b00, 1'b1);
        chk("sat_slip_pulse", bitslip, 1);
        chk("sat_hold", slip_count, 255);
        cyc(2'b00, 1'b1);
        reset = 1'b1;
        cyc(2'b00, 1'b1);
        reset = 1'b0;
        chk("midwait_bitslip", bitslip, 0);
        chk("midwait_lock", block_lock, 0);
        chk("midwait_err", hdr_err, 0);
        chk("midwait_cnt", slip_count, 0);
        chk("midwait_hiber", hi_ber, 0);
        n_slip_pulses = 0;
        good_n(LOCK);
        chk("post_rst_lock", block_lock, 1);
        chk("post_rst_no_slip", n_slip_pulses, 0);

`ifdef ETH_PHY_10G_BER_MON_EN
        // 16 bad in the first 1024 accepted headers, then a clean interval
        do_reset();
        good_n(LOCK);
        for (int i = 0; i < BERW - LOCK; i++) begin
            cyc((i % 60 == 0) ? 2'b11 : 2'b01, 1'b1);
            if (i == BERW - LOCK - 2) chk("ber_before", hi_ber, 0);
        end
        chk("ber_high", hi_ber, 1);
        chk("ber_lock_kept", block_lock, 1);
        good_n(BERW - 1);
        chk("ber_hold", hi_ber, 1);
        good_n(1);
        chk("ber_clear", hi_ber, 0);
`endif

        run_cmp = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
